fifo_sync: RTL and testbench

Parametrised synchronous FIFO: dual-port storage plus read/write pointers, occupancy count, full/empty and programmable almost-full/almost-empty flags, and overflow/underflow detection. It is the next generation of the project's raw storage array: the caller no longer manages addresses, only issues write/read requests. It sits between the packet source and consumer logic in the single-clock datapath.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_sync_if.sv | 38 +++
 rtl/fifo_mem_dp.sv | 31 +++
 rtl/fifo_sync.sv | 110 +++++++++++
 tb/tb_fifo_sync.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and types for the synchronous FIFO slice.
// Build option FIFO_STICKY_ERR_EN is consumed by fifo_sync.
package fifo_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 10;
  localparam int unsigned DEPTH_DEF      = 8;

  // Pointer width for a given depth (floor of 1 bit for degenerate sizes)
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int unsigned ADDR_WIDTH_DEF = addr_width(DEPTH_DEF);

  // Occupancy type for the default geometry: 0..DEPTH needs one extra bit
  typedef logic [ADDR_WIDTH_DEF:0] count_t;

endpackage

// File: rtl/fifo_sync_if.sv
// Request/response bundle between a FIFO user (master) and fifo_sync (slave).
interface fifo_sync_if
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned DEPTH      = DEPTH_DEF,
  localparam int unsigned ADDR_WIDTH = addr_width(DEPTH)
);

  logic [DATA_WIDTH-1:0] Fifo_Data_in;
  logic                  write_enable;
  logic                  read_enable;
  logic [ADDR_WIDTH:0]   umbral_af;
  logic [ADDR_WIDTH:0]   umbral_ae;

  logic [DATA_WIDTH-1:0] Fifo_Data_out;
  logic                  data_valid;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   fifo_count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output Fifo_Data_in, write_enable, read_enable, umbral_af, umbral_ae,
    input  Fifo_Data_out, data_valid, fifo_full, fifo_empty,
           almost_full, almost_empty, fifo_count, overflow, underflow
  );

  modport slave (
    input  Fifo_Data_in, write_enable, read_enable, umbral_af, umbral_ae,
    output Fifo_Data_out, data_valid, fifo_full, fifo_empty,
           almost_full, almost_empty, fifo_count, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem_dp.sv
// Dual-port storage array: one write port, one registered read port.
// No reset on the array or the read register; contents survive reset.
module fifo_mem_dp
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned DEPTH      = DEPTH_DEF,
  localparam int unsigned ADDR_WIDTH = addr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Read-before-write on an address collision: the read sees the old word
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= r_mem[rd_addr];
    end
  end

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO: pointers, occupancy, flags and overflow/underflow reporting.
// Define FIFO_STICKY_ERR_EN to make overflow/underflow hold until reset.
module fifo_sync
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned DEPTH      = DEPTH_DEF,
  localparam int unsigned ADDR_WIDTH = addr_width(DEPTH),
  localparam int unsigned CNT_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic        clk,
  input  logic        reset,
  fifo_sync_if.slave  bus
);

  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
    $error("fifo_sync: DEPTH must be a power of 2 and at least 4");
  end

  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [CNT_WIDTH-1:0]  r_count;
  logic                  r_data_valid;
  logic                  r_have_data;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic                  w_wr_rej;
  logic                  w_rd_rej;
  logic                  w_mem_wr;
  logic                  w_mem_rd;
  logic [DATA_WIDTH-1:0] w_rd_data;

  // Acceptance: a read frees a slot, so a full FIFO still takes a paired write
  always_comb begin
    w_full   = (r_count == CNT_FULL);
    w_empty  = (r_count == '0);
    w_rd_acc = bus.read_enable && !w_empty;
    w_wr_acc = bus.write_enable && (!w_full || w_rd_acc);
    w_wr_rej = bus.write_enable && !w_wr_acc;
    w_rd_rej = bus.read_enable && !w_rd_acc;
    w_mem_wr = w_wr_acc && !reset;
    w_mem_rd = w_rd_acc && !reset;
  end

  fifo_mem_dp #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (w_mem_wr),
    .wr_addr (r_wr_ptr),
    .wr_data (bus.Fifo_Data_in),
    .rd_en   (w_mem_rd),
    .rd_addr (r_rd_ptr),
    .rd_data (w_rd_data)
  );

  // Pointer, occupancy and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_data_valid <= 1'b0;
      r_have_data  <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      end
      if (w_wr_acc && !w_rd_acc) begin
        r_count <= r_count + CNT_WIDTH'(1);
      end else if (w_rd_acc && !w_wr_acc) begin
        r_count <= r_count - CNT_WIDTH'(1);
      end
      r_data_valid <= w_rd_acc;
      r_have_data  <= r_have_data || w_rd_acc;
`ifdef FIFO_STICKY_ERR_EN
      r_overflow   <= r_overflow  || w_wr_rej;
      r_underflow  <= r_underflow || w_rd_rej;
`else
      r_overflow   <= w_wr_rej;
      r_underflow  <= w_rd_rej;
`endif
    end
  end

  // Read register is not reset, so mask it to zero until the first accepted read
  assign bus.Fifo_Data_out = r_have_data ? w_rd_data : '0;
  assign bus.data_valid    = r_data_valid;
  assign bus.overflow      = r_overflow;
  assign bus.underflow     = r_underflow;
  assign bus.fifo_count    = r_count;
  assign bus.fifo_full     = w_full;
  assign bus.fifo_empty    = w_empty;
  assign bus.almost_full   = (r_count >= bus.umbral_af);
  assign bus.almost_empty  = (r_count <= bus.umbral_ae);

endmodule

// File: tb/tb_fifo_sync.sv
// Self-checking bench for fifo_sync: directed plan plus random traffic against a queue model.
module tb_fifo_sync;
  import fifo_pkg::*;

  localparam int unsigned DW = 10;
  localparam int unsigned DP = 8;

  logic clk = 1'b0;
  logic reset;

  fifo_sync_if #(.DATA_WIDTH(DW), .DEPTH(DP)) bus ();

  fifo_sync #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_out;
  logic          exp_valid;
  logic          exp_ovf;
  logic          exp_udf;
  count_t        af_thr;
  count_t        ae_thr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string ctx);
    int n;
    n = q.size();
    chk({ctx, ":count"},  32'(bus.fifo_count),    32'(n));
    chk({ctx, ":empty"},  32'(bus.fifo_empty),    32'(n == 0));
    chk({ctx, ":full"},   32'(bus.fifo_full),     32'(n == int'(DP)));
    chk({ctx, ":afull"},  32'(bus.almost_full),   32'(n >= int'(af_thr)));
    chk({ctx, ":aempty"}, 32'(bus.almost_empty),  32'(n <= int'(ae_thr)));
    chk({ctx, ":dout"},   32'(bus.Fifo_Data_out), 32'(exp_out));
    chk({ctx, ":valid"},  32'(bus.data_valid),    32'(exp_valid));
    chk({ctx, ":ovf"},    32'(bus.overflow),      32'(exp_ovf));
    chk({ctx, ":udf"},    32'(bus.underflow),     32'(exp_udf));
  endtask

  task automatic set_thr(input count_t af, input count_t ae);
    af_thr        = af;
    ae_thr        = ae;
    bus.umbral_af = af;
    bus.umbral_ae = ae;
  endtask

  // One clock of traffic; the model decides acceptance from the queue occupancy
  task automatic step(input string ctx, input logic we, input logic re, input logic [DW-1:0] din);
    bit rd;
    bit wr;
    bus.write_enable = we;
    bus.read_enable  = re;
    bus.Fifo_Data_in = din;
    rd = re && (q.size() > 0);
    wr = we && ((q.size() < int'(DP)) || rd);
    exp_valid = rd;
    if (rd) exp_out = q.pop_front();
    if (wr) q.push_back(din);
`ifdef FIFO_STICKY_ERR_EN
    exp_ovf = exp_ovf | (we && !wr);
    exp_udf = exp_udf | (re && !rd);
`else
    exp_ovf = we && !wr;
    exp_udf = re && !rd;
`endif
    @(posedge clk);
    #1;
    bus.write_enable = 1'b0;
    bus.read_enable  = 1'b0;
    check_all(ctx);
  endtask

  task automatic do_reset(input string ctx);
    reset            = 1'b1;
    bus.write_enable = 1'b1;
    bus.read_enable  = 1'b1;
    bus.Fifo_Data_in = 10'h3C3;
    q.delete();
    exp_out   = '0;
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
    exp_udf   = 1'b0;
    @(posedge clk);
    #1;
    reset            = 1'b0;
    bus.write_enable = 1'b0;
    bus.read_enable  = 1'b0;
    check_all(ctx);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset            = 1'b1;
    bus.write_enable = 1'b0;
    bus.read_enable  = 1'b0;
    bus.Fifo_Data_in = '0;
    set_thr(count_t'(6), count_t'(2));
    @(negedge clk);

    // Reset, then idle
    do_reset("reset");
    step("idle", 1'b0, 1'b0, '0);

    // Fill with 1..8, then one rejected write
    for (int i = 1; i <= 8; i++) step("fill", 1'b1, 1'b0, DW'(i));
    step("ovf_write", 1'b1, 1'b0, 10'h3FF);
    step("ovf_clear", 1'b0, 1'b0, '0);

    // Drain in order, then one rejected read
    for (int i = 0; i < 8; i++) step("drain", 1'b0, 1'b1, '0);
    step("udf_read", 1'b0, 1'b1, '0);
    step("udf_clear", 1'b0, 1'b0, '0);

    // Full plus simultaneous read/write
    for (int i = 0; i < 8; i++) step("refill", 1'b1, 1'b0, DW'($urandom));
    step("full_rw", 1'b1, 1'b1, 10'h155);
    for (int i = 0; i < 8; i++) step("drain_rw", 1'b0, 1'b1, '0);

    // Empty plus simultaneous read/write: write only
    step("empty_rw", 1'b1, 1'b1, 10'h2AA);
    step("read_2aa", 1'b0, 1'b1, '0);

    // Interleaved pairs so both pointers wrap
    for (int i = 0; i < 20; i++) begin
      step("wrap_wr", 1'b1, 1'b0, DW'($urandom));
      step("wrap_rd", 1'b0, 1'b1, '0);
    end

    // Threshold extremes take effect without a clock
    for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, 1'b0, DW'($urandom));
    set_thr(count_t'(0), count_t'(8));
    #1;
    check_all("thr_extreme");
    set_thr(count_t'(5), count_t'(4));
    #1;
    check_all("thr_edge");
    set_thr(count_t'(6), count_t'(2));
    step("ovf_seed", 1'b0, 1'b0, '0);

    // Reset mid-operation with requests asserted
    do_reset("mid_reset");

    // Random traffic with random thresholds
    for (int i = 0; i < 400; i++) begin
      if ((i % 37) == 0) set_thr(count_t'($urandom_range(0, 15)), count_t'($urandom_range(0, 15)));
      step("rand", 1'b1 && ($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50), DW'($urandom));
    end
    for (int i = 0; i < 10; i++) step("rand_fill", 1'b1, 1'b0, DW'($urandom));
    for (int i = 0; i < 10; i++) step("rand_drain", 1'b0, 1'b1, '0);
    do_reset("final_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
